// File: rtl/sort_block_feeder.sv
// sort_block_feeder: collects 32 signed samples and emits them as 8 beats of 4, then idles GAP_CYCLES.
// Define FEEDER_PAD_EN to let Flush pad a partial block with -128 and send it.
module sort_block_feeder #(
    parameter int GAP_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [7:0] Din,
    input  logic              DinValid,
    output logic              DinReady,
    input  logic              Flush,
    output logic signed [7:0] Out1,
    output logic signed [7:0] Out2,
    output logic signed [7:0] Out3,
    output logic signed [7:0] Out4,
    output logic              BlkIn,
    output logic              BeatValid
);
    typedef enum logic [1:0] {FILL, SEND, GAP} state_t;
    state_t            state, state_nxt;
    logic [5:0]        fill_cnt, fill_nxt, pad_start;
    logic [2:0]        beat, beat_nxt;
    logic [7:0]        gap_cnt, gap_nxt;
    logic signed [7:0] mem [32];
    logic signed [7:0] mem_nxt [32];
    logic signed [7:0] out_q [4];
    logic signed [7:0] out_nxt [4];
    logic              accept, flush_go;

    assign accept    = state == FILL && DinValid;
    assign pad_start = fill_cnt + 6'(accept);
`ifdef FEEDER_PAD_EN
    assign flush_go = state == FILL && Flush && fill_cnt != 6'd0;
`else
    assign flush_go = Flush & 1'b0;
`endif

    // Outputs are loaded from the next-cycle view of the buffer so beat 0 sees this edge's writes.
    always_comb begin
        mem_nxt   = mem;
        state_nxt = state;
        fill_nxt  = fill_cnt;
        beat_nxt  = beat;
        gap_nxt   = gap_cnt;
        if (accept) mem_nxt[fill_cnt[4:0]] = Din;
        for (int j = 0; j < 32; j++)
            if (flush_go && 6'(j) >= pad_start) mem_nxt[j] = 8'h80;
        case (state)
            FILL: begin
                fill_nxt = pad_start;
                if ((accept && fill_cnt == 6'd31) || flush_go) begin
                    state_nxt = SEND;
                    fill_nxt  = '0;
                    beat_nxt  = '0;
                end
            end
            SEND: begin
                beat_nxt = beat + 3'd1;
                if (beat == 3'd7) begin
                    state_nxt = GAP_CYCLES > 0 ? GAP : FILL;
                    gap_nxt   = '0;
                end
            end
            GAP: begin
                gap_nxt = gap_cnt + 8'd1;
                if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
                    state_nxt = FILL;
                    gap_nxt   = '0;
                end
            end
            default: state_nxt = FILL;
        endcase
        for (int i = 0; i < 4; i++)
            out_nxt[i] = state_nxt == SEND ? mem_nxt[{beat_nxt, 2'(i)}] : 8'sd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FILL;
            fill_cnt  <= '0;
            beat      <= '0;
            gap_cnt   <= '0;
            out_q     <= '{default: '0};
            BlkIn     <= 1'b0;
            BeatValid <= 1'b0;
            DinReady  <= 1'b1;
        end else begin
            state     <= state_nxt;
            fill_cnt  <= fill_nxt;
            beat      <= beat_nxt;
            gap_cnt   <= gap_nxt;
            out_q     <= out_nxt;
            BlkIn     <= state_nxt == SEND && beat_nxt == 3'd0;
            BeatValid <= state_nxt == SEND;
            DinReady  <= state_nxt == FILL;
        end
    end

    always_ff @(posedge clk) mem <= mem_nxt;

    assign Out1 = out_q[0];
    assign Out2 = out_q[1];
    assign Out3 = out_q[2];
    assign Out4 = out_q[3];
endmodule

// File: tb/tb_sort_block_feeder.sv
// tb_sort_block_feeder: drives a GAP_CYCLES=32 and a GAP_CYCLES=0 feeder against a queue-based schedule model.
module tb_sort_block_feeder;
    logic              clk, rst, DinValid, Flush;
    logic signed [7:0] Din;
    logic              rdy [2];
    logic              vld [2];
    logic              blk [2];
    logic signed [7:0] o [2][4];
    int                checks = 0, errors = 0;

    typedef struct packed {
        logic       rdy, vld, blk;
        logic [7:0] o0, o1, o2, o3;
    } rec_t;
    localparam rec_t FILL_R = '{rdy: 1'b1, default: '0};
    localparam rec_t GAP_R  = '{default: '0};
    localparam int   G [2]  = '{32, 0};

    rec_t       sched [2][$];
    logic [7:0] smp [2][$];
    rec_t       cur [2];

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        sort_block_feeder #(.GAP_CYCLES(G[g])) dut (
            .clk(clk), .rst(rst), .Din(Din), .DinValid(DinValid), .DinReady(rdy[g]),
            .Flush(Flush), .Out1(o[g][0]), .Out2(o[g][1]), .Out3(o[g][2]), .Out4(o[g][3]),
            .BlkIn(blk[g]), .BeatValid(vld[g])
        );
    end

    initial clk = 0;
    always #5 clk = ~clk;

    // Model: while no schedule is pending the feeder is filling; a completed block
    // schedules 8 beat cycles followed by G idle cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                smp[k].delete();
                sched[k].delete();
                cur[k] = FILL_R;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (cur[k].rdy) begin
                    int nb;
                    nb = smp[k].size();
                    if (DinValid) smp[k].push_back(Din);
`ifdef FEEDER_PAD_EN
                    if (Flush && nb > 0) while (smp[k].size() < 32) smp[k].push_back(8'h80);
`endif
                    if (smp[k].size() == 32) begin
                        for (int b = 0; b < 8; b++)
                            sched[k].push_back('{rdy: 1'b0, vld: 1'b1, blk: b == 0,
                                o0: smp[k][4*b], o1: smp[k][4*b+1], o2: smp[k][4*b+2], o3: smp[k][4*b+3]});
                        for (int q = 0; q < G[k]; q++) sched[k].push_back(GAP_R);
                        smp[k].delete();
                    end
                end
                cur[k] = sched[k].size() > 0 ? sched[k].pop_front() : FILL_R;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            rec_t got;
            got = {rdy[k], vld[k], blk[k], o[k][0], o[k][1], o[k][2], o[k][3]};
            checks++;
            if (got !== cur[k]) begin
                errors++;
                $display("FAIL cycle dut%0d t=%0t got %h expected %h", k, $time, got, cur[k]);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic feed(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            Din = 8'(first + i);
            DinValid = 1;
            @(posedge clk); #1;
        end
        DinValid = 0;
    endtask

    task automatic do_reset;
        rst = 0;
        @(posedge clk); #1;
        rst = 1;
    endtask

    initial begin
        int n, v;
        logic r;
        rst = 0; Din = 0; DinValid = 0; Flush = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy", rdy[0], 1);
        chk("reset_vld", vld[0], 0);
        rst = 1;
        feed(0, 32);
        chk("rdy_fall", rdy[0], 0);
        n = 0;
        while (!rdy[0] && n < 100) begin
            if (n == 0) begin
                chk("b0_blk", blk[0], 1);
                chk("b0_o1", o[0][0], 0); chk("b0_o2", o[0][1], 1);
                chk("b0_o3", o[0][2], 2); chk("b0_o4", o[0][3], 3);
            end
            if (n == 1) chk("b1_blk", blk[0], 0);
            if (n == 7) begin
                chk("b7_blk", blk[0], 0); chk("b7_vld", vld[0], 1);
                chk("b7_o1", o[0][0], 28); chk("b7_o2", o[0][1], 29);
                chk("b7_o3", o[0][2], 30); chk("b7_o4", o[0][3], 31);
            end
            if (n == 8) chk("gap0_rdy", rdy[1], 1);
            n++;
            @(posedge clk); #1;
        end
        chk("rdy_low_cycles", 8'(n), 40);
        v = 50;
        for (int t = 0; t < 200 && v < 82; t++) begin
            Din = 8'(v);
            DinValid = 1;
            r = rdy[0];
            @(posedge clk); #1;
            if (r) v++;
        end
        DinValid = 0;
        repeat (3000) begin
            DinValid = 1'($urandom);
            Din = 8'($urandom);
            Flush = ($urandom % 16) == 0;
            @(posedge clk); #1;
        end
        DinValid = 0; Flush = 0;
        do_reset;
        feed(20, 20);
        do_reset;
        feed(100, 32);
        chk("rst_blk", blk[0], 1);
        chk("rst_o1", o[0][0], 100); chk("rst_o2", o[0][1], 101);
        chk("rst_o3", o[0][2], 102); chk("rst_o4", o[0][3], 103);
        do_reset;
        feed(7, 5);
        Flush = 1;
        @(posedge clk); #1;
        Flush = 0;
`ifdef FEEDER_PAD_EN
        chk("pad_b0_blk", blk[0], 1);
        chk("pad_b0_o1", o[0][0], 7); chk("pad_b0_o4", o[0][3], 10);
        @(posedge clk); #1;
        chk("pad_b1_o1", o[0][0], 11); chk("pad_b1_o2", o[0][1], 8'h80);
        chk("pad_b1_o4", o[0][3], 8'h80);
        @(posedge clk); #1;
        chk("pad_b2_o1", o[0][0], 8'h80);
`else
        repeat (4) @(posedge clk);
        #1;
        chk("no_partial_vld", vld[0], 0);
        chk("no_partial_rdy", rdy[0], 1);
`endif
        repeat (50) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
